// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external pipelined adder between two requesters,
// with a tag pipeline steering each sum back to its issuer. Define ADDER_ARBITER_STATS_EN for grant counters.
module adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] adder_in_1,
  output logic [WIDTH-1:0] adder_in_2,
  input  logic [WIDTH:0]   adder_sum,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH:0]   rsp0_sum,
  output logic [WIDTH:0]   rsp1_sum
`ifdef ADDER_ARBITER_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  req_id_e last_grant;
  req_id_e grant_id;
  logic    handshake;
  tag_t    tag_pipe [LATENCY+1];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      // Requester 0 wins unless requester 1 also wants the adder and 0 went last.
      if (req0_valid && (!req1_valid || last_grant == REQ1)) req0_ready = 1'b1;
      else if (req1_valid)                                   req1_ready = 1'b1;
    end
  end

  assign handshake = req0_ready | req1_ready;
  assign grant_id  = req1_ready ? REQ1 : REQ0;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= REQ1;
      adder_in_1 <= '0;
      adder_in_2 <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_sum   <= '0;
      rsp1_sum   <= '0;
      // NOTE: the tag pipeline is reset (unlike a data RAM) because its valid bits must drop in-flight work.
      for (int i = 0; i <= LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      if (handshake) last_grant <= grant_id;
      adder_in_1 <= handshake ? (req1_ready ? req1_a : req0_a) : '0;
      adder_in_2 <= handshake ? (req1_ready ? req1_b : req0_b) : '0;
      tag_pipe[0] <= '{valid: handshake, id: grant_id};
      for (int i = 1; i <= LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      // The oldest tag lines up with the adder output sampled at this edge.
      rsp0_valid <= tag_pipe[LATENCY].valid && tag_pipe[LATENCY].id == REQ0;
      rsp1_valid <= tag_pipe[LATENCY].valid && tag_pipe[LATENCY].id == REQ1;
      if (tag_pipe[LATENCY].valid && tag_pipe[LATENCY].id == REQ0) rsp0_sum <= adder_sum;
      if (tag_pipe[LATENCY].valid && tag_pipe[LATENCY].id == REQ1) rsp1_sum <= adder_sum;
    end
  end

`ifdef ADDER_ARBITER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized and directed bench for adder_arbiter against a queue-based response model,
// with a behavioural 2-stage adder standing in for the shared adder.
module tb_adder_arbiter;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [W-1:0] adder_in_1, adder_in_2;
  logic [W:0]   adder_sum = '0;
  logic         rsp0_valid, rsp1_valid;
  logic [W:0]   rsp0_sum, rsp1_sum;
`ifdef ADDER_ARBITER_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  adder_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .adder_in_1(adder_in_1), .adder_in_2(adder_in_2), .adder_sum(adder_sum),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_sum(rsp0_sum), .rsp1_sum(rsp1_sum)
`ifdef ADDER_ARBITER_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clock = ~clock;

  // Shared two-stage adder outside the arbiter.
  logic [W:0] add_s1 = '0;
  always @(posedge clock) begin
    add_s1    <= {1'b0, adder_in_1} + {1'b0, adder_in_2};
    adder_sum <= add_s1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int grant_of(logic v0, logic v1, int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Reference model: ops queued with the edge at which their sum is captured.
  typedef struct {
    int         id;
    logic [W:0] sum;
    longint     due;
  } exp_t;

  exp_t         m_q[$];
  longint       cyc = 0;
  bit           model_ok = 0;
  int           m_last = 1;
  logic [W-1:0] m_in1 = '0, m_in2 = '0;
  logic         m_rv0 = 0, m_rv1 = 0;
  logic [W:0]   m_s0 = '0, m_s1 = '0;
  int           m_cnt0 = 0, m_cnt1 = 0;

  always @(posedge clock) begin
    int   g;
    exp_t e;
    if (reset) begin
      m_last = 1; m_in1 = '0; m_in2 = '0; m_q.delete();
      m_rv0 = 0; m_rv1 = 0; m_s0 = '0; m_s1 = '0;
      m_cnt0 = 0; m_cnt1 = 0;
      model_ok = 1;
    end else if (model_ok) begin
      g = grant_of(req0_valid, req1_valid, m_last);
      m_rv0 = 0; m_rv1 = 0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        e = m_q.pop_front();
        if (e.id == 0) begin m_rv0 = 1; m_s0 = e.sum; end
        else           begin m_rv1 = 1; m_s1 = e.sum; end
      end
      if (g == 0) begin
        m_in1 = req0_a; m_in2 = req0_b;
        m_q.push_back('{0, {1'b0, req0_a} + {1'b0, req0_b}, cyc + LAT + 1});
        if (m_cnt0 < 65535) m_cnt0++;
      end else if (g == 1) begin
        m_in1 = req1_a; m_in2 = req1_b;
        m_q.push_back('{1, {1'b0, req1_a} + {1'b0, req1_b}, cyc + LAT + 1});
        if (m_cnt1 < 65535) m_cnt1++;
      end else begin
        m_in1 = '0; m_in2 = '0;
      end
      if (g >= 0) m_last = g;
    end
    cyc++;
  end

  always @(negedge clock) begin
    int g;
    if (model_ok) begin
      g = reset ? -1 : grant_of(req0_valid, req1_valid, m_last);
      check("req0_ready", req0_ready, g == 0);
      check("req1_ready", req1_ready, g == 1);
      check("adder_in_1", adder_in_1, m_in1);
      check("adder_in_2", adder_in_2, m_in2);
      check("rsp0_valid", rsp0_valid, m_rv0);
      check("rsp1_valid", rsp1_valid, m_rv1);
      check("rsp0_sum", rsp0_sum, m_s0);
      check("rsp1_sum", rsp1_sum, m_s1);
`ifdef ADDER_ARBITER_STATS_EN
      check("grant_cnt0", grant_cnt0, m_cnt0);
      check("grant_cnt1", grant_cnt1, m_cnt1);
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(bit v0, bit v1, logic [W-1:0] a0, logic [W-1:0] b0,
                       logic [W-1:0] a1, logic [W-1:0] b1);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return W'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    do_reset();
    check("reset_adder_in_1", adder_in_1, 0);
    check("reset_rsp0_sum", rsp0_sum, 0);

    // Single requester 0: strobe exactly one cycle after edge k+3.
    drive(1, 0, 3827, 9273, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    check("lit_adder_in_1", adder_in_1, 3827);
    step(); step();
    @(negedge clock);
    check("lit_rsp0_early", rsp0_valid, 0);
    step();
    @(negedge clock);
    check("lit_rsp0_valid", rsp0_valid, 1);
    check("lit_rsp0_sum", rsp0_sum, 13100);
    check("lit_rsp1_quiet", rsp1_valid, 0);
    step();
    @(negedge clock);
    check("lit_rsp0_drop", rsp0_valid, 0);
    check("lit_rsp0_hold", rsp0_sum, 13100);

    // Both valid for six cycles straight after reset: 0,1,0,1,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, $urandom, $urandom, $urandom, $urandom);
      @(negedge clock);
      check("lit_rr_grant0", req0_ready, (i % 2) == 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();

    // Carry out of requester 1.
    drive(0, 1, 0, 0, 32'h0FFF_FFFF, 32'hFFFF_FFEF);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step(); step(); step();
    @(negedge clock);
    check("lit_rsp1_valid", rsp1_valid, 1);
    check("lit_rsp1_carry", rsp1_sum, 33'h1_0FFF_FFEE);
    step();

    // Reset one cycle after two back-to-back handshakes drops them.
    drive(0, 1, 5, 6, 7, 8);
    step();
    drive(1, 0, 1, 2, 3, 4);
    step();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("lit_no_stale_strobe", rsp0_valid | rsp1_valid, 0);
      step();
    end
    drive(1, 1, 10, 20, 30, 40);
    @(negedge clock);
    check("lit_post_reset_rr", req0_ready, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) step();

    // Requester 0 alone for 4 cycles, then requester 1 joins and wins.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, i, 100, 0, 0);
      step();
    end
    drive(1, 1, 50, 60, 70, 80);
    @(negedge clock);
    check("lit_join_grant1", req1_ready, 1);
    step();
    @(negedge clock);
    check("lit_join_in1", adder_in_1, 70);
    drive(0, 0, 0, 0, 0, 0);
    repeat (5) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            rnd_op(), rnd_op(), rnd_op(), rnd_op());
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();

`ifdef ADDER_ARBITER_STATS_EN
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    repeat (70000) step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    @(negedge clock);
    check("lit_cnt0_sat", grant_cnt0, 16'hFFFF);
    check("lit_cnt1_zero", grant_cnt1, 0);
    repeat (5) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
